// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter that shares one FIFO write port among NREQ producers.
// Grants are throttled by prog_full at grant time, and FIFO overflow cycles are counted.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DTA_WIDTH = 8,
    parameter int BURST_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DTA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [DTA_WIDTH-1:0]      fifo_din,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    input  logic                      fifo_prog_full,
    input  logic                      fifo_overflow,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [15:0]               ovf_count
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        w_nextGrant;
    logic [GW-1:0]        r_last;
    logic [GW-1:0]        w_nextLast;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_nextCnt;
    logic [15:0]          r_ovf;
    logic [GW-1:0]        w_winner;
    logic [GW-1:0]        w_cand;
    logic                 w_found;
    logic                 w_grantValid;
    logic                 w_transfer;
    logic [DTA_WIDTH-1:0] w_words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign w_words[g] = req_data[g*DTA_WIDTH +: DTA_WIDTH];
    end

    // Scan from the highest offset down so the nearest requester after r_last wins.
    always_comb begin
        w_winner = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = GW'((int'(r_last) + k) % NREQ);
            if (req_valid[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_grantValid = req_valid[r_grant];
    assign w_transfer   = (r_state == BURST) && w_grantValid && !fifo_full;
    assign fifo_wr_en   = w_transfer;
    assign fifo_din     = w_words[r_grant];
    assign grant_id     = r_grant;
    assign busy         = (r_state == BURST);
    assign ovf_count    = r_ovf;

    always_comb begin
        req_ready = '0;
        if (r_state == BURST && !fifo_full) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        w_nextLast  = r_last;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (arb_en && !fifo_prog_full && w_found) begin
                    w_nextState = BURST;
                    w_nextGrant = w_winner;
                    w_nextLast  = w_winner;
                    w_nextCnt   = '0;
                end
            end
            BURST: begin
                // A bubble from the granted requester ends the grant early.
                if (!w_grantValid) begin
                    w_nextState = IDLE;
                end else if (!fifo_full) begin
                    w_nextCnt = r_cnt + 1'b1;
                    if (r_cnt == CW'(BURST_LEN - 1)) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
            r_last  <= w_nextLast;
            r_cnt   <= w_nextCnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= '0;
        end else if (fifo_overflow && r_ovf != 16'hFFFF) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: table-driven cycle vectors plus a
// write scoreboard that compares every FIFO write against the expected word order.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        fifo_prog_full;
    logic        fifo_overflow;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] ovf_count;

    int          nChecks;
    int          nFails;
    logic [7:0]  expQ [$];
    logic [3:0]  seq [4];
    logic [3:0]  accPending;

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic       pfull;
        logic       en;
        logic [3:0] expReady;
        logic       expWr;
        logic       expBusy;
        logic [1:0] expGrant;
    } vec_t;

    vec_t vecs [$];

    fifo_wr_arbiter #(
        .NREQ(4),
        .DTA_WIDTH(8),
        .BURST_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arb_en(arb_en),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .fifo_prog_full(fifo_prog_full),
        .fifo_overflow(fifo_overflow),
        .grant_id(grant_id),
        .busy(busy),
        .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each producer emits {id, sequence} and advances after an accepted word.
    task automatic updateData();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = {i[3:0], seq[i]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (accPending[i]) seq[i] = seq[i] + 4'd1;
        end
        accPending = '0;
        updateData();
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid      = v.valid;
        fifo_full      = v.full;
        fifo_prog_full = v.pfull;
        arb_en         = v.en;
    endtask

    task automatic addVec(input logic [3:0] valid, input logic full, input logic pfull, input logic en,
                          input logic [3:0] expReady, input logic expWr, input logic expBusy,
                          input logic [1:0] expGrant);
        vec_t v;
        v.valid    = valid;
        v.full     = full;
        v.pfull    = pfull;
        v.en       = en;
        v.expReady = expReady;
        v.expWr    = expWr;
        v.expBusy  = expBusy;
        v.expGrant = expGrant;
        vecs.push_back(v);
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d] req_ready", tag, i), 32'(req_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("%s[%0d] fifo_wr_en", tag, i), 32'(fifo_wr_en), 32'(vecs[i].expWr));
            checkOutput($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("%s[%0d] grant_id", tag, i), 32'(grant_id), 32'(vecs[i].expGrant));
        end
        vecs.delete();
        checkOutput({tag, " scoreboard drained"}, 32'(expQ.size()), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        arb_en         = 1'b0;
        req_valid      = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        fifo_overflow  = 1'b0;
        accPending     = '0;
        for (int i = 0; i < 4; i++) seq[i] = '0;
        updateData();
        #2;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        checkOutput("reset ovf_count", 32'(ovf_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Write monitor: record handshakes for the producers and score every FIFO write.
    always @(negedge clk) begin
        if (rst) begin
            accPending = req_valid & req_ready;
            if (fifo_wr_en) begin
                checkOutput("wr_en while full", 32'(fifo_full), 32'd0);
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected write: got din %0h, expected no write", fifo_din);
                end else begin
                    checkOutput("fifo_din", 32'(fifo_din), 32'(expQ.pop_front()));
                end
            end
        end
    end

    logic [1:0] expGrants [5];

    initial begin
        nChecks        = 0;
        nFails         = 0;
        rst            = 1'b0;
        arb_en         = 1'b0;
        req_valid      = '0;
        req_data       = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        fifo_overflow  = 1'b0;
        accPending     = '0;
        for (int i = 0; i < 4; i++) seq[i] = '0;

        doReset();

        $display("[TB] single requester burst with full stall");
        for (int i = 0; i < 9; i++) expQ.push_back(8'(i));
        addVec(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) addVec(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) addVec(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) addVec(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0);
        addVec(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        addVec(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        runTable("single");

        doReset();
        $display("[TB] four requesters round robin");
        expGrants[0] = 2'd0;
        expGrants[1] = 2'd1;
        expGrants[2] = 2'd2;
        expGrants[3] = 2'd3;
        expGrants[4] = 2'd0;
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) expQ.push_back(8'(r * 16 + w));
        end
        for (int w = 8; w < 16; w++) expQ.push_back(8'(w));
        for (int n = 0; n < 45; n++) begin
            tick();
            if (n == 0) begin
                req_valid = 4'b1111;
                arb_en    = 1'b1;
            end
            @(negedge clk);
            if (n % 9 == 0) begin
                checkOutput($sformatf("rr idle busy n=%0d", n), 32'(busy), 32'd0);
            end else if (n % 9 == 1) begin
                checkOutput($sformatf("rr busy n=%0d", n), 32'(busy), 32'd1);
                checkOutput($sformatf("rr grant n=%0d", n), 32'(grant_id), 32'(expGrants[n / 9]));
            end
        end
        tick();
        req_valid = '0;
        tick();
        checkOutput("rr scoreboard drained", 32'(expQ.size()), 32'd0);

        doReset();
        $display("[TB] bubble ends grant, fairness");
        expQ.push_back(8'h20);
        expQ.push_back(8'h21);
        expQ.push_back(8'h30);
        expQ.push_back(8'h22);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        addVec(4'b1000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
        addVec(4'b1100, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
        addVec(4'b1100, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3);
        addVec(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
        runTable("bubble");

        doReset();
        $display("[TB] prog_full gating and arb_en");
        expQ.push_back(8'h10);
        expQ.push_back(8'h11);
        expQ.push_back(8'h12);
        for (int i = 0; i < 3; i++) addVec(4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        addVec(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        addVec(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        addVec(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        addVec(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1);
        addVec(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
        addVec(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
        addVec(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1);
        addVec(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1);
        addVec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1);
        runTable("progfull");

        $display("[TB] overflow counter and saturation");
        tick();
        fifo_overflow = 1'b1;
        tick();
        tick();
        tick();
        fifo_overflow = 1'b0;
        @(negedge clk);
        checkOutput("ovf_count after 3 pulses", 32'(ovf_count), 32'd3);
        tick();
        fifo_overflow = 1'b1;
        for (int n = 0; n < 65530; n++) tick();
        fifo_overflow = 1'b0;
        @(negedge clk);
        checkOutput("ovf_count near saturation", 32'(ovf_count), 32'hFFFD);
        tick();
        fifo_overflow = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        fifo_overflow = 1'b0;
        @(negedge clk);
        checkOutput("ovf_count saturated", 32'(ovf_count), 32'hFFFF);

        $display("[TB] reset during burst");
        tick();
        req_valid = 4'b0001;
        arb_en    = 1'b1;
        expQ.push_back(8'h00);
        expQ.push_back(8'h01);
        tick();
        tick();
        @(negedge clk);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midburst reset busy", 32'(busy), 32'd0);
        checkOutput("midburst reset fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        checkOutput("midburst reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("midburst reset ovf_count", 32'(ovf_count), 32'd0);
        checkOutput("midburst reset grant_id", 32'(grant_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checkOutput("final scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
